io_host_ctrl: RTL and testbench
===============================

IO_HOST_CTRL -- requirements
Module: io_host_ctrl

Interface
REQ-001 Parameter IO_DATA_WIDTH, default 16, width of each of the three bidirectional busses.
REQ-002 Parameter FEATURE_MAP_WIDTH, default 1024, range of output_x; FEATURE_MAP_HEIGHT, default 1024, range of output_y.
REQ-003 Parameter OUTPUT_NB_CHANNELS, default 64, range of output_ch.
REQ-004 Parameter RX_DEPTH, default 2, entries in the receive buffer, power of two, minimum 2.
REQ-005 Ports shall be: clk in 1 clock; rst_in in 1 synchronous reset, active-high; one clock domain.
REQ-006 tx_data in 3*IO_DATA_WIDTH host word, [IO_DATA_WIDTH-1:0] to bus_1, next slice to bus_2, top slice to bus_3; tx_valid in 1; tx_ready out 1.
REQ-007 bus_1, bus_2, bus_3 inout IO_DATA_WIDTH shared with chip; bus_valid out 1; bus_ready in 1; driving_busses in 1 chip owns busses.
REQ-008 output_valid in 1; output_x in $clog2(FEATURE_MAP_WIDTH); output_y in $clog2(FEATURE_MAP_HEIGHT); output_ch in $clog2(OUTPUT_NB_CHANNELS).
REQ-009 rx_data out 3*IO_DATA_WIDTH; rx_x, rx_y, rx_ch out, same widths as output_*; rx_valid out 1; rx_ready in 1.
REQ-010 bus_conflict out 1 sticky error; rx_overflow out 1 sticky error.

Function
REQ-011 FSM states shall be IDLE, DRIVE, LISTEN, TURN.
REQ-012 IDLE->DRIVE on tx_valid with driving_busses low; IDLE->LISTEN on driving_busses high.
REQ-013 DRIVE->LISTEN when driving_busses high; LISTEN->TURN when driving_busses low; TURN->IDLE after exactly one cycle; DRIVE->IDLE when hold register empty and tx_valid low.
REQ-014 Host output enable shall be (state==DRIVE) AND NOT driving_busses, combinationally; busses shall be 'z when disabled.
REQ-015 A one-entry hold register shall capture tx_data on tx_valid&tx_ready; tx_ready = NOT hold_valid OR bus transfer this cycle.
REQ-016 bus_valid = output enable AND hold_valid; bus transfer occurs on rising clk with bus_valid&bus_ready; hold data shall stay stable until transferred.
REQ-017 Back-to-back transfers shall sustain one word per cycle while bus_ready high.
REQ-018 driving_busses rising with hold_valid high shall keep the word held and resend after TURN; no word lost or duplicated.
REQ-019 bus_conflict shall set when driving_busses is high in a cycle where the registered state is DRIVE and bus_valid was high the previous cycle.
REQ-020 In LISTEN, output_valid high shall push {bus_3,bus_2,bus_1,output_x,output_y,output_ch} into the receive buffer; output_valid outside LISTEN shall be ignored.
REQ-021 Receive buffer shall present head on rx_* with rx_valid; pop on rx_valid&rx_ready; push and pop in the same cycle when full shall both succeed.
REQ-022 Push when full without simultaneous pop shall drop the new entry and set rx_overflow.
REQ-023 Write and read pointers shall wrap modulo RX_DEPTH.

Reset
REQ-024 rst_in high at a clock edge shall force: state IDLE, busses released, hold_valid 0, tx_ready 0 during reset, bus_valid 0, rx_valid 0, buffer empty, bus_conflict 0, rx_overflow 0, rx_* data 0.
REQ-025 Reset mid-transfer shall discard the held word; tx_ready shall be 1 in the first cycle after reset deassertion.

Configuration
REQ-026 With HOST_BUS_STATS_EN defined, outputs tx_word_count and rx_word_count, each 32 bits, shall count bus transfers and buffer pushes, reset to 0, wrap at 2^32.
REQ-027 Without HOST_BUS_STATS_EN, the counters and ports shall not exist; all other behaviour identical.

Structure
REQ-028 Package io_host_pkg shall hold the state enum host_state_e and struct rx_word_t (data, x, y, ch), parameterised via package constants matching module defaults.
REQ-029 Receive buffer shall be a sub-module io_host_rx_fifo instantiated once.

Verification
REQ-030 Send 0x0001_0002_0003 with bus_ready high -> bus_1=0x0003, bus_2=0x0002, bus_3=0x0001, bus_valid high one cycle, tx_ready high next cycle.
REQ-031 Stream 8 words, bus_ready toggling 1-0-1-0 -> exactly 8 transfers, order preserved, data stable while stalled.
REQ-032 Assert driving_busses mid-stream after word 3 -> busses 'z same cycle, word 4 resent after one TURN cycle, bus_conflict stays 0.
REQ-033 Chip pushes 3 outputs (x=5,y=7,ch=2 first) with rx_ready low, RX_DEPTH=2 -> first two held, rx_overflow=1, rx head x=5,y=7,ch=2.
REQ-034 Reset asserted with hold_valid high and buffer full -> all outputs at reset values next cycle, counters 0 when HOST_BUS_STATS_EN defined.

Source files
------------

// File: rtl/io_host_pkg.sv
// Shared types and default sizing for the host-side chip IO controller.
// Defaults here match the parameter defaults of io_host_ctrl.
package io_host_pkg;

  localparam int DEF_IO_DATA_WIDTH      = 16;
  localparam int DEF_FEATURE_MAP_WIDTH  = 1024;
  localparam int DEF_FEATURE_MAP_HEIGHT = 1024;
  localparam int DEF_OUTPUT_NB_CHANNELS = 64;
  localparam int DEF_RX_DEPTH           = 2;

  localparam int DEF_X_W  = $clog2(DEF_FEATURE_MAP_WIDTH);
  localparam int DEF_Y_W  = $clog2(DEF_FEATURE_MAP_HEIGHT);
  localparam int DEF_CH_W = $clog2(DEF_OUTPUT_NB_CHANNELS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    LISTEN = 2'd2,
    TURN   = 2'd3
  } host_state_e;

  typedef struct packed {
    logic [3*DEF_IO_DATA_WIDTH-1:0] data;
    logic [DEF_X_W-1:0]             x;
    logic [DEF_Y_W-1:0]             y;
    logic [DEF_CH_W-1:0]            ch;
  } rx_word_t;

endpackage

// File: rtl/io_host_rx_fifo.sv
// Receive buffer for chip output words; DEPTH must be a power of two (>= 2).
// A push into a full buffer with no pop in the same cycle is dropped and flagged.
module io_host_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_in,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_ready_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             valid_o,
  output logic             push_ok_o,
  output logic             overflow_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      cnt_q;
  logic             full, pop, overflow_q;

  assign full       = (cnt_q == (AW+1)'(DEPTH));
  assign valid_o    = (cnt_q != '0);
  assign pop        = valid_o && pop_ready_i;
  assign push_ok_o  = push_i && (!full || pop);
  assign rdata_o    = valid_o ? mem_q[rd_q] : '0;
  assign overflow_o = overflow_q;

  always_ff @(posedge clk) begin
    if (push_ok_o) mem_q[wr_q] <= wdata_i;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst_in) begin
      wr_q       <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok_o) wr_q <= wr_q + AW'(1);
      if (pop)       rd_q <= rd_q + AW'(1);
      if (push_ok_o && !pop)      cnt_q <= cnt_q + (AW+1)'(1);
      else if (pop && !push_ok_o) cnt_q <= cnt_q - (AW+1)'(1);
      if (push_i && full && !pop) overflow_q <= 1'b1;
    end
  end

endmodule

// File: rtl/io_host_ctrl.sv
// Host side of a half-duplex three-bus link to the accelerator chip.
// Optional transfer counters are built when HOST_BUS_STATS_EN is defined.
module io_host_ctrl
  import io_host_pkg::*;
#(
  parameter int IO_DATA_WIDTH      = DEF_IO_DATA_WIDTH,
  parameter int FEATURE_MAP_WIDTH  = DEF_FEATURE_MAP_WIDTH,
  parameter int FEATURE_MAP_HEIGHT = DEF_FEATURE_MAP_HEIGHT,
  parameter int OUTPUT_NB_CHANNELS = DEF_OUTPUT_NB_CHANNELS,
  parameter int RX_DEPTH           = DEF_RX_DEPTH
) (
  input  logic                                  clk,
  input  logic                                  rst_in,
  input  logic [3*IO_DATA_WIDTH-1:0]            tx_data,
  input  logic                                  tx_valid,
  output logic                                  tx_ready,
  inout  wire  [IO_DATA_WIDTH-1:0]              bus_1,
  inout  wire  [IO_DATA_WIDTH-1:0]              bus_2,
  inout  wire  [IO_DATA_WIDTH-1:0]              bus_3,
  output logic                                  bus_valid,
  input  logic                                  bus_ready,
  input  logic                                  driving_busses,
  input  logic                                  output_valid,
  input  logic [$clog2(FEATURE_MAP_WIDTH)-1:0]  output_x,
  input  logic [$clog2(FEATURE_MAP_HEIGHT)-1:0] output_y,
  input  logic [$clog2(OUTPUT_NB_CHANNELS)-1:0] output_ch,
  output logic [3*IO_DATA_WIDTH-1:0]            rx_data,
  output logic [$clog2(FEATURE_MAP_WIDTH)-1:0]  rx_x,
  output logic [$clog2(FEATURE_MAP_HEIGHT)-1:0] rx_y,
  output logic [$clog2(OUTPUT_NB_CHANNELS)-1:0] rx_ch,
  output logic                                  rx_valid,
  input  logic                                  rx_ready,
  output logic                                  bus_conflict,
  output logic                                  rx_overflow
`ifdef HOST_BUS_STATS_EN
  ,
  output logic [31:0]                           tx_word_count,
  output logic [31:0]                           rx_word_count
`endif
);

  localparam int DW  = 3 * IO_DATA_WIDTH;
  localparam int XW  = $clog2(FEATURE_MAP_WIDTH);
  localparam int YW  = $clog2(FEATURE_MAP_HEIGHT);
  localparam int CHW = $clog2(OUTPUT_NB_CHANNELS);
  localparam int RW  = DW + XW + YW + CHW;

  host_state_e   state_q;
  logic [DW-1:0] hold_q;
  logic          hold_vld_q, bus_valid_q, conflict_q;
  logic          oe, xfer, accept, push, push_ok;
  logic [RW-1:0] rx_word;

  // Host releases the busses the same cycle the chip claims them.
  assign oe        = !rst_in && (state_q == DRIVE) && !driving_busses;
  assign bus_valid = oe && hold_vld_q;
  assign xfer      = bus_valid && bus_ready;
  assign tx_ready  = !rst_in && (!hold_vld_q || xfer);
  assign accept    = tx_valid && tx_ready;
  assign push      = (state_q == LISTEN) && output_valid;

  assign bus_1 = oe ? hold_q[IO_DATA_WIDTH-1:0]              : 'z;
  assign bus_2 = oe ? hold_q[2*IO_DATA_WIDTH-1:IO_DATA_WIDTH] : 'z;
  assign bus_3 = oe ? hold_q[DW-1:2*IO_DATA_WIDTH]            : 'z;

  assign bus_conflict = conflict_q;

  always_ff @(posedge clk) begin
    if (accept) hold_q <= tx_data;
  end

  always_ff @(posedge clk) begin
    if (rst_in) begin
      state_q     <= IDLE;
      hold_vld_q  <= 1'b0;
      bus_valid_q <= 1'b0;
      conflict_q  <= 1'b0;
    end else begin
      bus_valid_q <= bus_valid;
      if (accept)    hold_vld_q <= 1'b1;
      else if (xfer) hold_vld_q <= 1'b0;
      if (driving_busses && (state_q == DRIVE) && bus_valid_q) conflict_q <= 1'b1;
      // A word left in the hold register re-enters DRIVE after the turnaround.
      unique case (state_q)
        IDLE: begin
          if (driving_busses)               state_q <= LISTEN;
          else if (tx_valid || hold_vld_q)  state_q <= DRIVE;
        end
        DRIVE: begin
          if (driving_busses)                 state_q <= LISTEN;
          else if (!hold_vld_q && !tx_valid)  state_q <= IDLE;
        end
        LISTEN: if (!driving_busses) state_q <= TURN;
        TURN:   state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  io_host_rx_fifo #(
    .WIDTH (RW),
    .DEPTH (RX_DEPTH)
  ) u_rx_fifo (
    .clk         (clk),
    .rst_in      (rst_in),
    .push_i      (push),
    .wdata_i     ({bus_3, bus_2, bus_1, output_x, output_y, output_ch}),
    .pop_ready_i (rx_ready),
    .rdata_o     (rx_word),
    .valid_o     (rx_valid),
    .push_ok_o   (push_ok),
    .overflow_o  (rx_overflow)
  );

  assign {rx_data, rx_x, rx_y, rx_ch} = rx_word;

`ifdef HOST_BUS_STATS_EN
  logic [31:0] tx_cnt_q, rx_cnt_q;

  always_ff @(posedge clk) begin
    if (rst_in) begin
      tx_cnt_q <= '0;
      rx_cnt_q <= '0;
    end else begin
      if (xfer)    tx_cnt_q <= tx_cnt_q + 32'd1;
      if (push_ok) rx_cnt_q <= rx_cnt_q + 32'd1;
    end
  end

  assign tx_word_count = tx_cnt_q;
  assign rx_word_count = rx_cnt_q;
`else
  logic unused_push_ok;
  assign unused_push_ok = push_ok;
`endif

endmodule

// File: tb/tb_io_host_ctrl.sv
// Directed and randomized bench for io_host_ctrl, checked against queue-based models.
// Counter checks are included when HOST_BUS_STATS_EN is defined.
module tb_io_host_ctrl;

  localparam int DW  = 16;
  localparam int XW  = 10;
  localparam int YW  = 10;
  localparam int CHW = 6;
  localparam int RXD = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_in = 1'b1;
  logic [3*DW-1:0]  tx_data = '0;
  logic             tx_valid = 1'b0;
  logic             tx_ready;
  wire  [DW-1:0]    bus_1, bus_2, bus_3;
  logic             bus_valid;
  logic             bus_ready = 1'b0;
  logic             driving_busses = 1'b0;
  logic             output_valid = 1'b0;
  logic [XW-1:0]    output_x = '0;
  logic [YW-1:0]    output_y = '0;
  logic [CHW-1:0]   output_ch = '0;
  logic [3*DW-1:0]  rx_data;
  logic [XW-1:0]    rx_x;
  logic [YW-1:0]    rx_y;
  logic [CHW-1:0]   rx_ch;
  logic             rx_valid;
  logic             rx_ready = 1'b0;
  logic             bus_conflict, rx_overflow;
`ifdef HOST_BUS_STATS_EN
  logic [31:0]      tx_word_count, rx_word_count;
`endif

  logic [DW-1:0] chip_b1 = '0, chip_b2 = '0, chip_b3 = '0;
  assign bus_1 = driving_busses ? chip_b1 : 'z;
  assign bus_2 = driving_busses ? chip_b2 : 'z;
  assign bus_3 = driving_busses ? chip_b3 : 'z;

  io_host_ctrl dut (
    .clk(clk), .rst_in(rst_in),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .bus_1(bus_1), .bus_2(bus_2), .bus_3(bus_3),
    .bus_valid(bus_valid), .bus_ready(bus_ready), .driving_busses(driving_busses),
    .output_valid(output_valid), .output_x(output_x), .output_y(output_y), .output_ch(output_ch),
    .rx_data(rx_data), .rx_x(rx_x), .rx_y(rx_y), .rx_ch(rx_ch),
    .rx_valid(rx_valid), .rx_ready(rx_ready),
    .bus_conflict(bus_conflict), .rx_overflow(rx_overflow)
`ifdef HOST_BUS_STATS_EN
    , .tx_word_count(tx_word_count), .rx_word_count(rx_word_count)
`endif
  );

  // bus_ready driver: 0 = hold br_val, 1 = toggle each cycle, 2 = random
  int   br_mode = 0;
  logic br_val  = 1'b0;
  always @(posedge clk) begin
    #1;
    case (br_mode)
      1:       bus_ready = ~bus_ready;
      2:       bus_ready = 1'($urandom_range(0, 1));
      default: bus_ready = br_val;
    endcase
  end

  // Transfer monitor: records every handshake and any stall where the word moved.
  logic [3*DW-1:0] got_q[$];
  logic            stall_prev = 1'b0;
  logic [3*DW-1:0] stall_data = '0;
  int              stall_bad = 0;
  int              xfer_total = 0;
  always @(negedge clk) begin
    if (rst_in) begin
      stall_prev = 1'b0;
      xfer_total = 0;
    end else begin
      if (stall_prev && !driving_busses && (!bus_valid || {bus_3, bus_2, bus_1} != stall_data))
        stall_bad++;
      if (bus_valid && bus_ready) begin
        got_q.push_back({bus_3, bus_2, bus_1});
        xfer_total++;
      end
      stall_prev = bus_valid && !bus_ready && !driving_busses;
      stall_data = {bus_3, bus_2, bus_1};
    end
  end

  int vectors = 0;
  int errors  = 0;
  logic [3*DW-1:0] sent_q[$];
  logic [3*DW+XW+YW+CHW-1:0] rxm[$];
  logic ovf_m;
  int   push_total;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input logic [3*DW-1:0] w);
    tx_data  = w;
    tx_valid = 1'b1;
    for (int c = 0; c < 40; c++) begin
      smp();
      if (tx_ready) begin
        sent_q.push_back(w);
        tick();
        tx_valid = 1'b0;
        return;
      end
      tick();
    end
    chk("send_timeout", tx_ready, 1'b1);
    tx_valid = 1'b0;
  endtask

  task automatic wait_got(input int n, input string tag);
    for (int c = 0; c < 80 && got_q.size() < n; c++) begin
      smp();
      tick();
    end
    chk(tag, got_q.size(), n);
  endtask

  task automatic compare_streams(input string tag);
    chk({tag, "_count"}, got_q.size(), sent_q.size());
    for (int i = 0; i < sent_q.size() && i < got_q.size(); i++)
      chk(tag, got_q[i], sent_q[i]);
  endtask

  task automatic check_rx_head(input string tag);
    logic [3*DW+XW+YW+CHW-1:0] e;
    chk({tag, "_valid"}, rx_valid, rxm.size() > 0);
    if (rxm.size() > 0) begin
      e = rxm[0];
      chk({tag, "_data"}, rx_data, e[3*DW+XW+YW+CHW-1:XW+YW+CHW]);
      chk({tag, "_xyc"}, {rx_x, rx_y, rx_ch}, e[XW+YW+CHW-1:0]);
    end
  endtask

  task automatic chip_rand();
    chip_b1 = DW'($urandom);
    chip_b2 = DW'($urandom);
    chip_b3 = DW'($urandom);
  endtask

  initial begin
    logic [3*DW-1:0] w;
    logic ov, rr, pop, full;

    // Reset values
    repeat (3) tick();
    smp();
    chk("rst_tx_ready", tx_ready, 1'b0);
    chk("rst_bus_valid", bus_valid, 1'b0);
    chk("rst_rx_valid", rx_valid, 1'b0);
    chk("rst_rx_data", rx_data, '0);
    chk("rst_conflict", bus_conflict, 1'b0);
    chk("rst_overflow", rx_overflow, 1'b0);
    tick();
    rst_in = 1'b0;
    smp();
    chk("post_rst_tx_ready", tx_ready, 1'b1);
    tick();
    br_val = 1'b1;
    repeat (2) tick();

    // Single word, bus slice ordering
    send(48'h0001_0002_0003);
    smp();
    chk("single_bus_valid", bus_valid, 1'b1);
    chk("single_bus_1", bus_1, 16'h0003);
    chk("single_bus_2", bus_2, 16'h0002);
    chk("single_bus_3", bus_3, 16'h0001);
    tick();
    smp();
    chk("single_valid_drop", bus_valid, 1'b0);
    chk("single_tx_ready", tx_ready, 1'b1);
    tick();
    compare_streams("single_word");

    // Eight words with bus_ready toggling
    got_q.delete();
    sent_q.delete();
    br_mode = 1;
    for (int i = 0; i < 8; i++) send({16'(i), 32'($urandom)});
    wait_got(8, "toggle_wait");
    repeat (4) tick();
    br_mode = 0;
    compare_streams("toggle_stream");
    chk("toggle_stall_stable", stall_bad, 0);

    // Chip takes the busses after word 3; word 4 follows the turnaround
    repeat (3) tick();
    got_q.delete();
    sent_q.delete();
    for (int i = 0; i < 3; i++) send({16'h3300 + 16'(i), 32'($urandom)});
    wait_got(3, "turn_wait3");
    tick();
    driving_busses = 1'b1;
    chip_b1 = '0;
    chip_b2 = '0;
    chip_b3 = '0;
    send(48'h4444_5555_6666);
    smp();
    chk("turn_bus_1_released", bus_1, 16'h0000);
    chk("turn_bus_3_released", bus_3, 16'h0000);
    chk("turn_bus_valid", bus_valid, 1'b0);
    tick();
    tick();
    driving_busses = 1'b0;
    wait_got(4, "turn_wait4");
    repeat (4) tick();
    compare_streams("turn_stream");
    chk("turn_no_conflict", bus_conflict, 1'b0);

    // Chip grabs the busses during a stalled handshake
    br_val = 1'b0;
    repeat (3) tick();
    got_q.delete();
    sent_q.delete();
    send(48'hABCD_1234_5678);
    smp();
    chk("stall_bus_valid", bus_valid, 1'b1);
    tick();
    driving_busses = 1'b1;
    smp();
    chk("grab_bus_valid", bus_valid, 1'b0);
    chk("grab_bus_2", bus_2, 16'h0000);
    tick();
    smp();
    chk("grab_conflict", bus_conflict, 1'b1);
    tick();
    driving_busses = 1'b0;
    br_val = 1'b1;
    wait_got(1, "resend_wait");
    repeat (6) tick();
    compare_streams("resend");
    chk("conflict_sticky", bus_conflict, 1'b1);

    // Three chip outputs into a two-entry buffer with rx_ready low
    driving_busses = 1'b1;
    repeat (3) tick();
    rxm.delete();
    ovf_m = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chip_rand();
      output_x  = (i == 0) ? 10'd5 : 10'($urandom);
      output_y  = (i == 0) ? 10'd7 : 10'($urandom);
      output_ch = (i == 0) ? 6'd2  : 6'($urandom);
      output_valid = 1'b1;
      if (rxm.size() < RXD) rxm.push_back({chip_b3, chip_b2, chip_b1, output_x, output_y, output_ch});
      else ovf_m = 1'b1;
      tick();
      if (i == 1) begin
        smp();
        chk("ovf_before_third", rx_overflow, 1'b0);
      end
    end
    output_valid = 1'b0;
    smp();
    chk("ovf_set", rx_overflow, ovf_m);
    chk("head_xyc_literal", {rx_x, rx_y, rx_ch}, {10'd5, 10'd7, 6'd2});
    check_rx_head("full_head");
    tick();
    rx_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      smp();
      check_rx_head("drain");
      tick();
      void'(rxm.pop_front());
    end
    smp();
    chk("drained_empty", rx_valid, 1'b0);
    tick();

    // Chip outputs outside LISTEN are ignored
    driving_busses = 1'b0;
    tick();
    output_valid = 1'b1;
    repeat (3) tick();
    output_valid = 1'b0;
    smp();
    chk("ignore_outside_listen", rx_valid, 1'b0);
    tick();

    // Reset with a held word and a full buffer
    rx_ready = 1'b0;
    driving_busses = 1'b1;
    repeat (3) tick();
    output_valid = 1'b1;
    repeat (2) tick();
    output_valid = 1'b0;
    tx_data  = 48'hDEAD_BEEF_CAFE;
    tx_valid = 1'b1;
    smp();
    chk("pre_rst_hold_accept", tx_ready, 1'b1);
    tick();
    tx_valid = 1'b0;
    smp();
    chk("pre_rst_full", rx_valid, 1'b1);
    tick();
    rst_in = 1'b1;
    driving_busses = 1'b0;
    tick();
    smp();
    chk("rst2_tx_ready", tx_ready, 1'b0);
    chk("rst2_bus_valid", bus_valid, 1'b0);
    chk("rst2_rx_valid", rx_valid, 1'b0);
    chk("rst2_rx_word", {rx_data, rx_x}, '0);
    chk("rst2_conflict", bus_conflict, 1'b0);
    chk("rst2_overflow", rx_overflow, 1'b0);
`ifdef HOST_BUS_STATS_EN
    chk("rst2_tx_count", tx_word_count, 0);
    chk("rst2_rx_count", rx_word_count, 0);
`endif
    tick();
    got_q.delete();
    sent_q.delete();
    rst_in = 1'b0;
    smp();
    chk("rst2_first_tx_ready", tx_ready, 1'b1);
    repeat (8) tick();
    chk("rst2_word_discarded", got_q.size(), 0);

    // Randomized transmit stream
    br_mode = 2;
    for (int i = 0; i < 20; i++) begin
      repeat ($urandom_range(0, 2)) tick();
      w = {16'($urandom), 32'($urandom)};
      send(w);
    end
    br_mode = 0;
    br_val  = 1'b1;
    wait_got(20, "rand_tx_wait");
    repeat (4) tick();
    compare_streams("rand_tx");
    chk("rand_stall_stable", stall_bad, 0);

    // Randomized receive traffic against a bounded-queue model
    driving_busses = 1'b1;
    repeat (3) tick();
    rxm.delete();
    ovf_m = 1'b0;
    push_total = 0;
    for (int i = 0; i < 40; i++) begin
      ov = 1'($urandom_range(0, 1));
      rr = 1'($urandom_range(0, 1));
      chip_rand();
      output_x  = 10'($urandom);
      output_y  = 10'($urandom);
      output_ch = 6'($urandom);
      output_valid = ov;
      rx_ready = rr;
      smp();
      check_rx_head("rand_rx");
      chk("rand_rx_overflow", rx_overflow, ovf_m);
      full = (rxm.size() == RXD);
      pop  = rr && (rxm.size() > 0);
      if (pop) void'(rxm.pop_front());
      if (ov && (!full || pop)) begin
        rxm.push_back({chip_b3, chip_b2, chip_b1, output_x, output_y, output_ch});
        push_total++;
      end else if (ov) begin
        ovf_m = 1'b1;
      end
      tick();
    end
    output_valid = 1'b0;
    rx_ready = 1'b0;
    smp();
    check_rx_head("rand_rx_final");
`ifdef HOST_BUS_STATS_EN
    chk("tx_word_count", tx_word_count, xfer_total);
    chk("rx_word_count", rx_word_count, push_total);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
